// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction fetch unit: bus widths, hold levels,
// the NOP/zero constants presented to IF/ID, the fetch FSM state encoding and
// the {addr, inst} entry layout stored in the prefetch FIFO.
// ----------------------------------------------------------------------------
package if_fetch_pkg;

  localparam int INST_W      = 32;  // InstBus
  localparam int INST_ADDR_W = 32;  // InstAddrBus
  localparam int HOLD_W      = 3;   // Hold_Flag_Bus

  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'b000;
  localparam logic [HOLD_W-1:0] HOLD_PC   = 3'b001;
  localparam logic [HOLD_W-1:0] HOLD_IF   = 3'b010;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'b011;

  localparam logic [INST_W-1:0]      INST_NOP  = 32'h0000_0001;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_ST_BOOT  = 2'b00,
    IF_ST_RUN   = 2'b01,
    IF_ST_DRAIN = 2'b10
  } if_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// ----------------------------------------------------------------------------
// if_fifo
// Small synchronous FIFO (power-of-2 depth) with push, pop and flush.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (control only)
//   push/push_data  write an entry (ignored when full unless popping)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push and pop
//   head            oldest entry (undefined when count == 0)
//   count           number of stored entries
// ----------------------------------------------------------------------------
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count < FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
// Instruction fetch unit. Issues PC-sequential requests on a req/gnt/rvalid
// bus, buffers returned words with their addresses in a prefetch FIFO and
// presents the FIFO head to the IF/ID register. A jump reloads the PC,
// flushes the FIFO and drops every response still owed by the bus.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   jump_flag_i, jump_addr_i     redirect from execute
//   hold_flag_i                  pipeline hold level
//   ibus_req_o, ibus_addr_o      bus request (stable until ibus_gnt_i)
//   ibus_gnt_i, ibus_rvalid_i,   bus grant / in-order read response
//   ibus_rdata_i
//   inst_o, inst_addr_o,         FIFO head (NOP / zero when invalid)
//   inst_valid_o
//   pc_o                         next request address
// Optional (macro IF_PERF_CNT_EN):
//   perf_fetch_cnt_o             count of instructions popped
//   perf_stall_cnt_o             count of cycles starved with the FIFO empty
// ----------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0]      hold_flag_i,
  output logic                   ibus_req_o,
  output logic [INST_ADDR_W-1:0] ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [INST_W-1:0]      ibus_rdata_i,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid_o,
  output logic [INST_ADDR_W-1:0] pc_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt_o,
  output logic [31:0]            perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  if_state_e              state;
  logic [INST_ADDR_W-1:0] pc;
  logic [INST_ADDR_W-1:0] stale_addr;
  logic                   pend;
  logic                   stale;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          discard_dec;
  logic [CW-1:0]          discard_jump;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          out_next;
  logic [CW-1:0]          fifo_count;
  logic [INST_ADDR_W-1:0] resp_addr;
  fetch_entry_t           fifo_head;
  logic                   fifo_empty;
  logic                   new_req;
  logic                   grant;
  logic                   push;
  logic                   pop;

  // A fresh request needs room for its response: buffered plus in-flight
  // words may never exceed the FIFO depth, so a push can never overflow.
  assign new_req = (state == IF_ST_RUN) && !jump_flag_i && (hold_flag_i < HOLD_PC) &&
                   (({1'b0, fifo_count} + {1'b0, outstanding}) < {1'b0, DEPTH_C});

  // A pending request is never retracted; after a jump it keeps its old address.
  assign ibus_req_o  = pend || new_req;
  assign ibus_addr_o = stale ? stale_addr : pc;
  assign grant       = ibus_req_o && ibus_gnt_i;

  assign out_next     = outstanding + {{(CW-1){1'b0}}, grant} - {{(CW-1){1'b0}}, ibus_rvalid_i};
  // Everything still owed by the bus after a jump is stale, including a
  // request that is waiting for its grant.
  assign discard_jump = out_next + {{(CW-1){1'b0}}, (ibus_req_o && !ibus_gnt_i)};
  assign discard_dec  = (ibus_rvalid_i && (discard != '0)) ? (discard - ONE) : discard;

  assign fifo_empty = (fifo_count == '0);
  assign push       = ibus_rvalid_i && (discard == '0) && !jump_flag_i;
  assign pop        = !fifo_empty && (hold_flag_i < HOLD_IF) && !jump_flag_i;

  assign inst_valid_o = !fifo_empty && !jump_flag_i;
  assign inst_o       = inst_valid_o ? fifo_head.inst : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? fifo_head.addr : ZERO_WORD;
  assign pc_o         = pc;

  // Addresses of granted requests, in order; its occupancy is the number of
  // outstanding requests and its head tags each returning word.
  if_fifo #(.WIDTH(INST_ADDR_W), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (ibus_addr_o),
    .pop       (ibus_rvalid_i),
    .flush     (1'b0),
    .head      (resp_addr),
    .count     (outstanding)
  );

  if_fifo #(.WIDTH(INST_ADDR_W + INST_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({resp_addr, ibus_rdata_i}),
    .pop       (pop),
    .flush     (jump_flag_i),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IF_ST_BOOT;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      stale   <= 1'b0;
      discard <= '0;
    end else begin
      pend <= ibus_req_o && !ibus_gnt_i;
      if (jump_flag_i) begin
        pc      <= jump_addr_i;
        stale   <= ibus_req_o && !ibus_gnt_i;
        discard <= discard_jump;
        state   <= (discard_jump != '0) ? IF_ST_DRAIN : IF_ST_RUN;
      end else begin
        if (grant) stale <= 1'b0;
        // A stale grant belongs to the old stream and must not move the new PC.
        if (grant && !stale) pc <= pc + 32'd4;
        discard <= discard_dec;
        unique case (state)
          IF_ST_BOOT:  state <= IF_ST_RUN;
          IF_ST_DRAIN: if (discard_dec == '0) state <= IF_ST_RUN;
          default:     state <= state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (jump_flag_i) stale_addr <= ibus_addr_o;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_o <= 32'd0;
      perf_stall_cnt_o <= 32'd0;
    end else begin
      if (pop) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (fifo_empty && !jump_flag_i && (hold_flag_i < HOLD_IF))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch
// Bench for if_fetch. A bus model grants requests and returns words in order
// with randomised latency; word content is a fixed function of the address.
// The reference model is the architectural instruction stream: every popped
// instruction must be the next sequential address of the current stream
// (restarting at each jump target) with its memory word, and the request
// address must follow the same stream, with a request that was waiting for
// its grant at a jump completing at its old address.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .pc_o          (pc_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;

  logic [31:0] bus_q[$];
  int          bus_t[$];

  logic [31:0] exp_req;
  logic [31:0] exp_fetch;
  bit          held;
  bit          held_stale;
  logic [31:0] held_addr;
  bit          prev_frozen;
  logic [31:0] prev_inst;
  logic [31:0] prev_iaddr;
  int          m_fetch;
  int          m_stall;

  logic        last_req;
  logic [31:0] last_addr;
  logic [31:0] last_pc;
  logic        last_valid;
  logic [31:0] last_iaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at the falling edge, observe 1 ns later.
  task automatic tick(input bit jmp, input logic [31:0] jaddr, input logic [2:0] hold,
                      input int gpct, input int rpct);
    bit rv;
    bit pop_ev;
    jump_flag_i = jmp;
    jump_addr_i = jaddr;
    hold_flag_i = hold;
    ibus_gnt_i  = ($urandom_range(0, 99) < gpct);
    rv = 1'b0;
    if (bus_q.size() > 0)
      if (bus_t[0] < cyc && $urandom_range(0, 99) < rpct) rv = 1'b1;
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rv ? mem_word(bus_q[0]) : $urandom();
    if (rv) begin
      void'(bus_q.pop_front());
      void'(bus_t.pop_front());
    end
    #1;
    last_req = ibus_req_o; last_addr = ibus_addr_o; last_pc = pc_o;
    last_valid = inst_valid_o; last_iaddr = inst_addr_o;

    total++;
    if (pc_o !== exp_req) begin
      bad++; $display("FAIL pc_o: got %h expected %h (cycle %0d)", pc_o, exp_req, cyc);
    end
    if (held) begin
      total++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== held_addr) begin
        bad++; $display("FAIL req_stable: got req=%b addr=%h expected req=1 addr=%h", ibus_req_o, ibus_addr_o, held_addr);
      end
    end else if (ibus_req_o === 1'b1) begin
      total++;
      if (ibus_addr_o !== exp_req) begin
        bad++; $display("FAIL req_addr: got %h expected %h", ibus_addr_o, exp_req);
      end
    end
    if (!held && hold >= HOLD_PC) begin
      total++;
      if (ibus_req_o !== 1'b0) begin
        bad++; $display("FAIL req_hold: got req=%b expected 0 with hold=%0d", ibus_req_o, hold);
      end
    end
    if (jmp) begin
      total++;
      if (inst_valid_o !== 1'b0) begin
        bad++; $display("FAIL jump_nop: got valid=%b expected 0", inst_valid_o);
      end
    end
    if (inst_valid_o !== 1'b1) begin
      total++;
      if (inst_o !== INST_NOP || inst_addr_o !== ZERO_WORD) begin
        bad++; $display("FAIL idle_out: got inst=%h addr=%h expected %h %h", inst_o, inst_addr_o, INST_NOP, ZERO_WORD);
      end
    end
    if (prev_frozen && !jmp) begin
      total++;
      if (inst_valid_o !== 1'b1 || inst_o !== prev_inst || inst_addr_o !== prev_iaddr) begin
        bad++; $display("FAIL hold_frozen: got v=%b %h@%h expected 1 %h@%h", inst_valid_o, inst_o, inst_addr_o, prev_inst, prev_iaddr);
      end
    end
    pop_ev = (inst_valid_o === 1'b1) && (hold < HOLD_IF) && !jmp;
    if (pop_ev) begin
      total++;
      if (inst_addr_o !== exp_fetch || inst_o !== mem_word(exp_fetch)) begin
        bad++; $display("FAIL fetch: got %h@%h expected %h@%h", inst_o, inst_addr_o, mem_word(exp_fetch), exp_fetch);
      end
      exp_fetch = exp_fetch + 32'd4;
      pops++;
    end
`ifdef IF_PERF_CNT_EN
    total++;
    if (perf_fetch_cnt_o !== 32'(m_fetch) || perf_stall_cnt_o !== 32'(m_stall)) begin
      bad++; $display("FAIL perf: got fetch=%0d stall=%0d expected %0d %0d", perf_fetch_cnt_o, perf_stall_cnt_o, m_fetch, m_stall);
    end
    if (pop_ev) m_fetch++;
    if (inst_valid_o !== 1'b1 && !jmp && hold < HOLD_IF) m_stall++;
`endif
    prev_frozen = (inst_valid_o === 1'b1) && (hold >= HOLD_IF) && !jmp;
    prev_inst   = inst_o;
    prev_iaddr  = inst_addr_o;

    if (ibus_req_o === 1'b1) begin
      if (ibus_gnt_i) begin
        bus_q.push_back(ibus_addr_o);
        bus_t.push_back(cyc);
        if (!held_stale) exp_req = exp_req + 32'd4;
        held = 1'b0;
        held_stale = 1'b0;
        total++;
        if (bus_q.size() > DEPTH) begin
          bad++; $display("FAIL outstanding: got %0d expected <= %0d", bus_q.size(), DEPTH);
        end
      end else begin
        if (!held) held_addr = ibus_addr_o;
        held = 1'b1;
      end
    end
    if (jmp) begin
      if (held) held_stale = 1'b1;
      exp_req   = jaddr;
      exp_fetch = jaddr;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = HOLD_NONE;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    #1;
    total++;
    if (ibus_req_o !== 1'b0 || ibus_addr_o !== RESET_PC || pc_o !== RESET_PC) begin
      bad++; $display("FAIL reset_bus: got req=%b addr=%h pc=%h expected 0 %h %h", ibus_req_o, ibus_addr_o, pc_o, RESET_PC, RESET_PC);
    end
    total++;
    if (inst_o !== INST_NOP || inst_addr_o !== ZERO_WORD || inst_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_out: got %h@%h v=%b expected NOP@0 v=0", inst_o, inst_addr_o, inst_valid_o);
    end
`ifdef IF_PERF_CNT_EN
    total++;
    if (perf_fetch_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin
      bad++; $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_fetch_cnt_o, perf_stall_cnt_o);
    end
`endif
    bus_q.delete(); bus_t.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_req = RESET_PC; exp_fetch = RESET_PC;
    held = 1'b0; held_stale = 1'b0; prev_frozen = 1'b0;
    m_fetch = 0; m_stall = 0;
  endtask

  task automatic test_boot();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, HOLD_NONE, 100, 100);
      if (i == 0) begin
        total++;
        if (last_req !== 1'b0) begin bad++; $display("FAIL boot_idle: got req=%b expected 0", last_req); end
      end
      if (i == 1) begin
        total++;
        if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
          bad++; $display("FAIL boot_first_req: got req=%b addr=%h expected 1 %h", last_req, last_addr, RESET_PC);
        end
      end
      if (i == 2 || i == 3) begin
        total++;
        if (last_valid !== (i == 3) || (i == 3 && last_iaddr !== RESET_PC)) begin
          bad++; $display("FAIL boot_first_valid: cycle %0d got v=%b addr=%h expected v=%0d addr=%h", i, last_valid, last_iaddr, i == 3, RESET_PC);
        end
      end
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a;
    int k;
    k = 0;
    tick(1'b0, '0, HOLD_NONE, 0, 100);
    while (last_req !== 1'b1 && k < 20) begin
      tick(1'b0, '0, HOLD_NONE, 0, 100);
      k++;
    end
    total++;
    if (last_req !== 1'b1) begin bad++; $display("FAIL stall_req_seen: got req=%b expected 1", last_req); end
    a = last_addr;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, HOLD_NONE, 0, 100);
      total++;
      if (last_req !== 1'b1 || last_addr !== a || last_pc !== a) begin
        bad++; $display("FAIL stall_stable: got req=%b addr=%h pc=%h expected 1 %h %h", last_req, last_addr, last_pc, a, a);
      end
    end
    repeat (6) tick(1'b0, '0, HOLD_NONE, 100, 100);
  endtask

  task automatic test_hold_if();
    logic [31:0] ia;
    repeat (3) tick(1'b0, '0, HOLD_NONE, 100, 100);
    repeat (4) tick(1'b0, '0, HOLD_IF, 100, 100);
    ia = last_iaddr;
    repeat (4) tick(1'b0, '0, HOLD_IF, 100, 100);
    total++;
    if (last_req !== 1'b0 || last_valid !== 1'b1 || last_iaddr !== ia) begin
      bad++; $display("FAIL hold_if_end: got req=%b v=%b addr=%h expected 0 1 %h", last_req, last_valid, last_iaddr, ia);
    end
    repeat (6) tick(1'b0, '0, HOLD_NONE, 100, 100);
  endtask

  task automatic test_jump_drain();
    repeat (6) tick(1'b0, '0, HOLD_NONE, 100, 0);
    total++;
    if (bus_q.size() != DEPTH) begin bad++; $display("FAIL drain_setup: got %0d outstanding expected %0d", bus_q.size(), DEPTH); end
    tick(1'b1, 32'h0000_0100, HOLD_NONE, 100, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, HOLD_NONE, 100, 0);
      total++;
      if (last_req !== 1'b0) begin bad++; $display("FAIL drain_no_req: got req=%b expected 0", last_req); end
    end
    repeat (10) tick(1'b0, '0, HOLD_NONE, 100, 100);
    total++;
    if (exp_fetch == 32'h0000_0100) begin bad++; $display("FAIL drain_resume: got no fetch from %h expected progress", exp_fetch); end
  endtask

  task automatic test_jump_pending();
    logic [31:0] a;
    int k;
    k = 0;
    tick(1'b0, '0, HOLD_NONE, 0, 100);
    while (last_req !== 1'b1 && k < 20) begin
      tick(1'b0, '0, HOLD_NONE, 0, 100);
      k++;
    end
    a = last_addr;
    tick(1'b1, 32'h0000_0200, HOLD_NONE, 0, 100);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, HOLD_NONE, 0, 100);
      total++;
      if (last_req !== 1'b1 || last_addr !== a || last_pc !== 32'h0000_0200) begin
        bad++; $display("FAIL pend_old_addr: got req=%b addr=%h pc=%h expected 1 %h 00000200", last_req, last_addr, last_pc, a);
      end
    end
    repeat (12) tick(1'b0, '0, HOLD_NONE, 100, 100);
    total++;
    if (exp_fetch == 32'h0000_0200) begin bad++; $display("FAIL pend_resume: got no fetch from %h expected progress", exp_fetch); end
  endtask

  task automatic test_wrap();
    tick(1'b1, 32'hFFFF_FFF8, HOLD_NONE, 100, 100);
    repeat (16) tick(1'b0, '0, HOLD_NONE, 100, 100);
    total++;
    if (exp_fetch > 32'h0000_0100) begin bad++; $display("FAIL wrap: got next fetch %h expected wrapped low address", exp_fetch); end
  endtask

  task automatic test_random();
    int p0;
    int gp;
    int rp;
    logic [31:0] ja;
    logic [2:0]  h;
    p0 = pops;
    gp = 70; rp = 60;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin gp = $urandom_range(20, 100); rp = $urandom_range(20, 100); end
      if (i == 750) test_reset();
      h = ($urandom_range(0, 9) < 7) ? HOLD_NONE : 3'($urandom_range(1, 3));
      ja = $urandom() & 32'hFFFF_FFFC;
      tick($urandom_range(0, 99) < 4, ja, h, gp, rp);
    end
    repeat (20) tick(1'b0, '0, HOLD_NONE, 100, 100);
    total++;
    if (pops - p0 < 100) begin bad++; $display("FAIL random_progress: got %0d pops expected >= 100", pops - p0); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    repeat (30) tick(1'b0, '0, HOLD_NONE, 100, 100);
    repeat (5) tick(1'b0, '0, HOLD_IF, 100, 100);
    repeat (10) tick(1'b0, '0, HOLD_NONE, 50, 50);
    tick(1'b0, '0, HOLD_NONE, 100, 100);
    total++;
    if (m_fetch < 10 || m_stall < 3) begin bad++; $display("FAIL perf_coverage: got fetch=%0d stall=%0d expected >= 10 and >= 3", m_fetch, m_stall); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    test_reset();
    test_boot();
    test_gnt_stall();
    test_hold_if();
    test_jump_drain();
    test_jump_pending();
    test_wrap();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout at %0t expected completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch unit; produces the instruction/address stream consumed by the IF/ID pipeline register.
- Generates the PC and issues requests on a req/gnt/rvalid instruction bus.
- Buffers returned words in a small prefetch FIFO.
- Honours pipeline hold flags and redirects on jump, discarding in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum number of outstanding bus requests (power of 2, >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
jump_flag_i  input  1  redirect request from execute
jump_addr_i  input  32  redirect target
hold_flag_i  input  3  pipeline hold level (`Hold_Flag_Bus`)
ibus_req_o  output  1  bus request
ibus_addr_o  output  32  bus request address
ibus_gnt_i  input  1  request accepted this cycle
ibus_rvalid_i  input  1  read data valid, in request order
ibus_rdata_i  input  32  read data
inst_o  output  32  instruction to IF/ID (`InstBus`)
inst_addr_o  output  32  instruction address to IF/ID (`InstAddrBus`)
inst_valid_o  output  1  inst_o holds a real fetched instruction
pc_o  output  32  next request address

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=BOOT.
  - ibus_req_o=0, ibus_addr_o=RESET_PC, inst_o=`INST_NOP`, inst_addr_o=`ZeroWord`, inst_valid_o=0.
- States:
  - BOOT: one cycle, no request, then RUN.
  - RUN: normal fetch.
  - DRAIN: discard>0; stale responses are dropped; go to RUN when discard reaches 0.
- Request issue:
  - Conditions: ibus_req_o=1 in RUN when (fifo_count + outstanding) < FIFO_DEPTH and hold_flag_i < `Hold_Pc`, or when a request is already pending without gnt.
  - ibus_addr_o=pc.
  - Once asserted, req and addr stay stable until gnt; hold does not retract a pending req.
  - On gnt: pc += 4 (wraps modulo 2^32); outstanding +1.
- Response:
  - rvalid decrements outstanding.
  - If discard>0, the word is dropped and discard decrements.
  - Otherwise {addr, rdata} is pushed to the FIFO, with addr tracked by an in-order request-address queue.
  - rvalid with gnt in the same cycle: outstanding unchanged.
- Output:
  - inst_o/inst_addr_o = FIFO head and inst_valid_o=1 when the FIFO is non-empty; otherwise `INST_NOP`, `ZeroWord`, 0.
  - Combinational from FIFO state; IF/ID registers them.
- Pop: FIFO non-empty && hold_flag_i < `Hold_If` && !jump_flag_i. Pop and push may occur in the same cycle.
- Jump (jump_flag_i=1):
  - pc <= jump_addr_i; FIFO flushed.
  - discard <= outstanding (adjusted for same-cycle gnt/rvalid).
  - state <= DRAIN if that value >0, else RUN.
  - A req pending without gnt still completes at its old address and is counted into discard.
  - Outputs show NOP during the jump cycle.
  - Jump has priority over hold and pop.
- Hold:
  - `Hold_Pc`: blocks new requests; FIFO still fills from outstanding responses.
  - >=`Hold_If`: also blocks pop, and the output head stays stable.
- Jump while in DRAIN: discard recomputed from the current outstanding count; pc reloaded.
- Reset mid-transaction: all counters cleared; late rvalid after reset deassertion is a protocol violation and is not supported.
- Full: no request issued when the FIFO plus outstanding requests would exceed FIFO_DEPTH, so a push never overflows.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt_o[31:0] and perf_stall_cnt_o[31:0].
  - perf_fetch_cnt_o increments on each pop.
  - perf_stall_cnt_o increments each cycle with FIFO empty, no jump, and hold_flag_i < `Hold_If`.
  - Both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; no other change.

Decomposition:
- defines.v holds `InstBus`, `InstAddrBus`, `Hold_Flag_Bus`, `Hold_Pc`, `Hold_If`, `INST_NOP`, `ZeroWord`, and new `IF_ST_BOOT`/`IF_ST_RUN`/`IF_ST_DRAIN` encodings (2-bit).
- Sub-module if_fifo: parameterised synchronous FIFO (width 64 {addr,inst}, depth FIFO_DEPTH) with push/pop/flush/count, same clk/rst convention.

Test Plan:
- Reset release, bus always grants, rvalid one cycle after gnt -> first req at 0x0 after BOOT; inst_addr_o sequence 0x0, 0x4, 0x8 with inst_valid_o=1 from cycle 3.
- ibus_gnt_i held low 5 cycles -> ibus_req_o and ibus_addr_o=0x4 stable throughout; pc_o stays 0x4.
- hold_flag_i=`Hold_If` for 4 cycles with 2 words buffered -> no new req, inst_o/inst_addr_o frozen at 0x8, then resume 0x8, 0xC.
- Jump to 0x100 with 2 outstanding requests -> state DRAIN; the two responses (0x10, 0x14) are never output; next valid inst_addr_o=0x100.
- Jump to 0x200 while req at 0x20 is ungranted -> req held at 0x20 until gnt, its data discarded, next req 0x200.
- IF_PERF_CNT_EN defined: 10 pops and 3 empty-unheld cycles -> perf_fetch_cnt_o=10, perf_stall_cnt_o=3.
